demux1x2_stream: RTL
====================

Name: demux1x2_stream

Overview:
- Registered 1-to-2 stream demultiplexer: the distributing counterpart of the 2:1 select path.
- Takes one valid/ready input stream and steers each word to output channel 0 or 1.
- Steering is either by an explicit select bit or by automatic alternation.
- Each output channel has a one-entry holding register and a delivered-word counter; the block feeds two parallel consumers (e.g. two datapath lanes) from one producer.

Parameters:
- WIDTH, 8, data word width in bits.
- CW, 8, width of each per-channel delivered-word counter.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  producer has a word on in_data.
- in_ready  output  1  block accepts the word this cycle.
- in_data  input  WIDTH  input word.
- in_sel  input  1  target channel when alt=0; ignored when alt=1.
- alt  input  1  1 = alternate channels automatically, 0 = use in_sel.
- out0_valid  output  1  channel 0 register holds a word.
- out0_ready  input  1  channel 0 consumer takes the word.
- out0_data  output  WIDTH  channel 0 word.
- out1_valid  output  1  channel 1 register holds a word.
- out1_ready  input  1  channel 1 consumer takes the word.
- out1_data  output  WIDTH  channel 1 word.
- ptr  output  1  current alternation pointer (next target when alt=1).
- count0  output  CW  words delivered on channel 0.
- count1  output  CW  words delivered on channel 1.

Behaviour:
- One clock, clk. Reset is asynchronous and active-high on rst.
- While rst=1, every register clears immediately: out0_valid=0, out1_valid=0, out0_data=0, out1_data=0, ptr=0, count0=0, count1=0. Words held at reset are discarded, not delivered.
- Target channel: t = alt ? ptr : in_sel, combinational.
- in_ready = ~outT_valid | outT_ready. This is combinational from alt, in_sel, ptr, the valid flags and the out ready signals.
- in_ready must not depend on in_valid.
- Accept = in_valid & in_ready.
- On accept at a rising edge: outT_data <= in_data and outT_valid <= 1. The word is visible at the output one cycle after acceptance.
- Output handshake on channel k = outk_valid & outk_ready.
- On a channel handshake without a simultaneous load of that channel, outk_valid <= 0 and outk_data is held.
- Simultaneous handshake and load on the same channel: outk_valid stays 1 and outk_data takes the new word, giving full throughput with no bubble.
- Independent channels: a load on one channel and a handshake on the other are both performed in the same cycle.
- The non-target channel's state never blocks in_ready.
- ptr toggles only on an accept while alt=1. It holds when alt=0 or when no accept occurs. ptr is not reset by changes to alt.
- countk increments by 1 on each channel k handshake and wraps from 2^CW-1 to 0. There is no saturation or overflow flag.
- outk_data is stable while outk_valid=1 and outk_ready=0.
- When alt=1 and the target channel is full and stalled, input stalls even if the other channel is empty. There is no skip-ahead; strict alternation order is kept.

Test Plan:
- Reset mid-traffic: assert rst while out0_valid=1, count0=5 -> out0_valid=0, out0_data=0, count0=0, ptr=0 immediately, without waiting for a clock edge.
- Explicit steering, alt=0: send 0xA5 with in_sel=0, then 0x3C with in_sel=1, both out ready held 1 -> out0_data=0xA5 one cycle after the first accept and out1_data=0x3C one cycle after the second; count0=1, count1=1.
- Backpressure: out0_ready=0, in_sel=0, send 0x11 then 0x22 -> 0x11 is held, in_ready=0 while in_sel=0; switching in_sel=1 gives in_ready=1 and 0x22 goes to channel 1.
- Full throughput: out0_ready=1, in_valid=1, in_sel=0 for 4 cycles with words 1,2,3,4 -> four consecutive handshakes, out0_valid never drops, count0=4.
- Alternation: alt=1, stream 0x10..0x15 with both ready=1 -> channel 0 gets 0x10,0x12,0x14 and channel 1 gets 0x11,0x13,0x15; ptr=0 at the end.
- Counter wrap: CW=8, deliver 257 words on channel 1 -> count1=1.

Source files
------------

// File: rtl/demux1x2_stream_if.sv
// Stream bundle for the 1-to-2 demultiplexer: one producer-facing input
// stream plus two consumer-facing output channels.
interface demux1x2_stream_if #(
    parameter int unsigned WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             in_sel;
    logic             alt;
    logic             out0_valid;
    logic             out0_ready;
    logic [WIDTH-1:0] out0_data;
    logic             out1_valid;
    logic             out1_ready;
    logic [WIDTH-1:0] out1_data;

    // Environment side: drives the producer stream and the consumer readies.
    modport master (
        output in_valid, in_data, in_sel, alt, out0_ready, out1_ready,
        input  in_ready, out0_valid, out0_data, out1_valid, out1_data
    );

    // Demultiplexer side.
    modport slave (
        input  in_valid, in_data, in_sel, alt, out0_ready, out1_ready,
        output in_ready, out0_valid, out0_data, out1_valid, out1_data
    );
endinterface

// File: rtl/demux1x2_stream.sv
// Registered 1-to-2 stream demultiplexer. Each input word is steered either
// by in_sel or by an alternating pointer into a one-entry holding register
// per channel. Each channel counts delivered words with a wrapping counter.
module demux1x2_stream #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CW    = 8
) (
    input  logic                clk,
    input  logic                rst,
    demux1x2_stream_if.slave    bus,
    output logic                ptr,
    output logic [CW-1:0]       count0,
    output logic [CW-1:0]       count1
);
    logic             v0_q, v0_d, v1_q, v1_d;
    logic [WIDTH-1:0] d0_q, d0_d, d1_q, d1_d;
    logic             ptr_q, ptr_d;
    logic [CW-1:0]    cnt0_q, cnt0_d, cnt1_q, cnt1_d;

    logic tgt, rdy, acc, load0, load1, hs0, hs1;

    // Target selection and input ready; ready only looks at the target channel.
    always_comb begin
        tgt   = bus.alt ? ptr_q : bus.in_sel;
        rdy   = tgt ? (~v1_q | bus.out1_ready) : (~v0_q | bus.out0_ready);
        acc   = bus.in_valid & rdy;
        load0 = acc & ~tgt;
        load1 = acc & tgt;
        hs0   = v0_q & bus.out0_ready;
        hs1   = v1_q & bus.out1_ready;
    end

    // Next-state: a load wins over a handshake so back-to-back words never bubble.
    always_comb begin
        v0_d   = v0_q;
        d0_d   = d0_q;
        v1_d   = v1_q;
        d1_d   = d1_q;
        ptr_d  = ptr_q;
        cnt0_d = cnt0_q;
        cnt1_d = cnt1_q;
        if (load0) begin
            v0_d = 1'b1;
            d0_d = bus.in_data;
        end else if (hs0) begin
            v0_d = 1'b0;
        end
        if (load1) begin
            v1_d = 1'b1;
            d1_d = bus.in_data;
        end else if (hs1) begin
            v1_d = 1'b0;
        end
        if (hs0) cnt0_d = cnt0_q + 1'b1;
        if (hs1) cnt1_d = cnt1_q + 1'b1;
        if (acc && bus.alt) ptr_d = ~ptr_q;
    end

    // State registers; reset discards any held words.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v0_q   <= 1'b0;
            d0_q   <= '0;
            v1_q   <= 1'b0;
            d1_q   <= '0;
            ptr_q  <= 1'b0;
            cnt0_q <= '0;
            cnt1_q <= '0;
        end else begin
            v0_q   <= v0_d;
            d0_q   <= d0_d;
            v1_q   <= v1_d;
            d1_q   <= d1_d;
            ptr_q  <= ptr_d;
            cnt0_q <= cnt0_d;
            cnt1_q <= cnt1_d;
        end
    end

    assign bus.in_ready   = rdy;
    assign bus.out0_valid = v0_q;
    assign bus.out0_data  = d0_q;
    assign bus.out1_valid = v1_q;
    assign bus.out1_data  = d1_q;
    assign ptr            = ptr_q;
    assign count0         = cnt0_q;
    assign count1         = cnt1_q;
endmodule
